// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand select + write-back forwarding into a 2-entry skid buffer feeding the ALU.
module alu_operand_stage #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_rs1_idx,
  input  logic [1:0]           in_rs2_idx,
  input  logic [WORD_SIZE-1:0] in_rs1_data,
  input  logic [WORD_SIZE-1:0] in_rs2_data,
  input  logic [7:0]           in_imm,
  input  logic [1:0]           in_imm_mode,
  input  logic [3:0]           in_op,
  input  logic [1:0]           in_dest,
  input  logic                 flush,
  input  logic                 wb_en,
  input  logic [1:0]           wb_dest,
  input  logic [WORD_SIZE-1:0] wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_a,
  output logic [WORD_SIZE-1:0] out_b,
  output logic [3:0]           out_op,
  output logic [1:0]           out_dest
);
  typedef struct packed {
    logic [WORD_SIZE-1:0] a;
    logic [WORD_SIZE-1:0] b;
    logic [3:0]           op;
    logic [1:0]           dest;
    logic [1:0]           rs1;
    logic [1:0]           rs2;
    logic [1:0]           mode;
  } entry_t;
  entry_t r_m, r_s, w_in, w_m_hold, w_s_hold;
  logic r_m_valid, r_s_valid;
  logic w_acc, w_xfer;
  assign in_ready  = !r_s_valid;
  assign w_acc     = in_valid && in_ready;
  assign w_xfer    = r_m_valid && out_ready;
  assign out_valid = r_m_valid;
  assign out_a     = r_m.a;
  assign out_b     = r_m.b;
  assign out_op    = r_m.op;
  assign out_dest  = r_m.dest;
  always_comb begin
    w_in.a    = (wb_en && wb_dest == in_rs1_idx) ? wb_data : in_rs1_data;
    w_in.b    = in_imm_mode == 2'd0 ? ((wb_en && wb_dest == in_rs2_idx) ? wb_data : in_rs2_data) :
                in_imm_mode == 2'd1 ? {{(WORD_SIZE-8){in_imm[7]}}, in_imm} :
                in_imm_mode == 2'd2 ? WORD_SIZE'(in_imm) : WORD_SIZE'({in_imm, 8'h00});
    w_in.op   = in_op;
    w_in.dest = in_dest;
    w_in.rs1  = in_rs1_idx;
    w_in.rs2  = in_rs2_idx;
    w_in.mode = in_imm_mode;
    // Held entries keep tracking write-backs; immediates are never overwritten.
    w_m_hold   = r_m;
    w_m_hold.a = (wb_en && wb_dest == r_m.rs1) ? wb_data : r_m.a;
    w_m_hold.b = (wb_en && r_m.mode == 2'd0 && wb_dest == r_m.rs2) ? wb_data : r_m.b;
    w_s_hold   = r_s;
    w_s_hold.a = (wb_en && wb_dest == r_s.rs1) ? wb_data : r_s.a;
    w_s_hold.b = (wb_en && r_s.mode == 2'd0 && wb_dest == r_s.rs2) ? wb_data : r_s.b;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m       <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (!r_m_valid || w_xfer) begin
      r_m_valid <= r_s_valid || w_acc;
      r_s_valid <= 1'b0;
      if (r_s_valid) r_m <= w_s_hold;
      else if (w_acc) r_m <= w_in;
    end else begin
      r_m <= w_m_hold;
      r_s_valid <= r_s_valid || w_acc;
      r_s <= w_acc ? w_in : w_s_hold;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: table-driven vectors with a scoreboard queue, plus stall/forwarding/flush/reset sequences.
module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        reset_n, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [1:0]  in_rs1_idx, in_rs2_idx, in_imm_mode, in_dest, wb_dest, out_dest;
  logic [15:0] in_rs1_data, in_rs2_data, wb_data, out_a, out_b;
  logic [7:0]  in_imm;
  logic [3:0]  in_op, out_op;

  always #5 clk = ~clk;

  alu_operand_stage #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_imm_mode(in_imm_mode), .in_op(in_op),
    .in_dest(in_dest), .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_op(out_op), .out_dest(out_dest)
  );

  typedef struct {
    logic [1:0]  rs1, rs2;
    logic [15:0] d1, d2;
    logic [7:0]  imm;
    logic [1:0]  mode;
    logic [3:0]  op;
    logic [1:0]  dest;
    logic        wen;
    logic [1:0]  wdst;
    logic [15:0] wdat, ea, eb;
  } vec_t;
  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  op;
    logic [1:0]  dest;
  } exp_t;

  exp_t sbq[$];
  exp_t m_e;
  vec_t tbl[9];
  int   n_cmp = 0, n_err = 0, retries = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    in_rs1_idx = v.rs1; in_rs2_idx = v.rs2; in_rs1_data = v.d1; in_rs2_data = v.d2;
    in_imm = v.imm; in_imm_mode = v.mode; in_op = v.op; in_dest = v.dest;
    wb_en = v.wen; wb_dest = v.wdst; wb_data = v.wdat;
  endtask

  // Offers one instruction until accepted; its expectation enters the scoreboard at acceptance.
  task automatic drive(input vec_t v);
    exp_t e;
    apply(v);
    in_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready && !flush && reset_n) begin
        e.a = v.ea; e.b = v.eb; e.op = v.op; e.dest = v.dest;
        sbq.push_back(e);
        step();
        in_valid = 1'b0;
        return;
      end
      retries++;
      step();
    end
    n_cmp++;
    n_err++;
    $display("FAIL drive_timeout actual=no_accept required=accept");
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset_n || flush) sbq.delete();
    else if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL xfer_unexpected actual a=%h b=%h required=none", out_a, out_b);
      end else begin
        m_e = sbq.pop_front();
        check("xfer_a", out_a, m_e.a);
        check("xfer_b", out_b, m_e.b);
        check("xfer_op", {12'h0, out_op}, {12'h0, m_e.op});
        check("xfer_dest", {14'h0, out_dest}, {14'h0, m_e.dest});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t v, v2;
    int   r0;
    tbl[0] = '{2'd0, 2'd1, 16'h1111, 16'h0000, 8'hF0, 2'd1, 4'h1, 2'd2, 1'b0, 2'd0, 16'h0000, 16'h1111, 16'hFFF0};
    tbl[1] = '{2'd0, 2'd1, 16'h2222, 16'h0000, 8'hF0, 2'd2, 4'h2, 2'd3, 1'b0, 2'd0, 16'h0000, 16'h2222, 16'h00F0};
    tbl[2] = '{2'd0, 2'd1, 16'h3333, 16'h0000, 8'hF0, 2'd3, 4'h3, 2'd0, 1'b0, 2'd0, 16'h0000, 16'h3333, 16'hF000};
    tbl[3] = '{2'd2, 2'd3, 16'h0000, 16'h5555, 8'h00, 2'd0, 4'h4, 2'd1, 1'b1, 2'd2, 16'h1234, 16'h1234, 16'h5555};
    tbl[4] = '{2'd0, 2'd1, 16'h0101, 16'hAAAA, 8'h00, 2'd0, 4'h5, 2'd2, 1'b1, 2'd1, 16'h7777, 16'h0101, 16'h7777};
    tbl[5] = '{2'd0, 2'd1, 16'h0202, 16'hAAAA, 8'h7F, 2'd1, 4'h6, 2'd3, 1'b1, 2'd1, 16'h9999, 16'h0202, 16'h007F};
    tbl[6] = '{2'd0, 2'd0, 16'h0001, 16'h0002, 8'h00, 2'd0, 4'h7, 2'd0, 1'b1, 2'd0, 16'hCAFE, 16'hCAFE, 16'hCAFE};
    tbl[7] = '{2'd3, 2'd2, 16'hABCD, 16'hFFFF, 8'h01, 2'd3, 4'hF, 2'd1, 1'b0, 2'd0, 16'h0000, 16'hABCD, 16'h0100};
    tbl[8] = '{2'd1, 2'd2, 16'h0000, 16'h0000, 8'h80, 2'd1, 4'h8, 2'd2, 1'b1, 2'd2, 16'h4444, 16'h0000, 16'hFF80};
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    apply('{2'd0, 2'd0, 16'h0, 16'h0, 8'h0, 2'd0, 4'h0, 2'd0, 1'b0, 2'd0, 16'h0, 16'h0, 16'h0});
    step(); step();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_out_op", {12'h0, out_op}, 0);
    check("rst_out_dest", {14'h0, out_dest}, 0);
    step();
    reset_n = 1'b1;
    // Single ADD issue: visible the very next cycle, gone the cycle after.
    drive('{2'd0, 2'd1, 16'h0005, 16'h0003, 8'h00, 2'd0, 4'h0, 2'd1, 1'b0, 2'd0, 16'h0, 16'h0005, 16'h0003});
    @(negedge clk);
    check("single_valid", out_valid, 1);
    check("single_a", out_a, 16'h0005);
    check("single_b", out_b, 16'h0003);
    step();
    @(negedge clk);
    check("single_valid_after", out_valid, 0);
    step();
    // Back-to-back table at full throughput.
    r0 = retries;
    foreach (tbl[i]) drive(tbl[i]);
    wb_en = 1'b0;
    repeat (3) step();
    check("tbl_retries", 16'(retries - r0), 0);
    check("tbl_drained", 16'(sbq.size()), 0);
    // Stall: two accepted, third waits until drain, no gaps.
    out_ready = 1'b0;
    drive('{2'd0, 2'd0, 16'h00A1, 16'h00B1, 8'h00, 2'd2, 4'h1, 2'd1, 1'b0, 2'd0, 16'h0, 16'h00A1, 16'h0000});
    drive('{2'd0, 2'd0, 16'h00A2, 16'h00B2, 8'h02, 2'd2, 4'h2, 2'd2, 1'b0, 2'd0, 16'h0, 16'h00A2, 16'h0002});
    @(negedge clk);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_a", out_a, 16'h00A1);
    step();
    fork
      drive('{2'd0, 2'd0, 16'h00A3, 16'h00B3, 8'h03, 2'd2, 4'h3, 2'd3, 1'b0, 2'd0, 16'h0, 16'h00A3, 16'h0003});
      begin
        step(); step();
        @(negedge clk);
        check("stall_held_a", out_a, 16'h00A1);
        step();
        out_ready = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("drain_no_gap", out_valid, 1);
          @(posedge clk);
        end
      end
    join
    #1;
    repeat (2) step();
    check("stall_drained", 16'(sbq.size()), 0);
    // Hold-time forwarding into main on rs2.
    out_ready = 1'b0;
    drive('{2'd3, 2'd1, 16'h3333, 16'h1111, 8'h00, 2'd0, 4'h2, 2'd3, 1'b0, 2'd0, 16'h0, 16'h3333, 16'h1111});
    wb_en = 1'b1; wb_dest = 2'd1; wb_data = 16'hBEEF;
    step();
    wb_en = 1'b0;
    @(negedge clk);
    check("hold_fwd_b", out_b, 16'hBEEF);
    check("hold_keep_a", out_a, 16'h3333);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    // Immediate operand must ignore the same write-back.
    drive('{2'd3, 2'd1, 16'h3333, 16'h1111, 8'h22, 2'd1, 4'h2, 2'd3, 1'b0, 2'd0, 16'h0, 16'h3333, 16'h0022});
    wb_en = 1'b1; wb_dest = 2'd1; wb_data = 16'hBEEF;
    step();
    wb_en = 1'b0;
    @(negedge clk);
    check("hold_imm_b", out_b, 16'h0022);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    // Hold-time forwarding into the skid entry, observed at drain.
    drive('{2'd0, 2'd0, 16'h0A0A, 16'h0000, 8'h05, 2'd2, 4'h9, 2'd1, 1'b0, 2'd0, 16'h0, 16'h0A0A, 16'h0005});
    drive('{2'd2, 2'd2, 16'h0B0B, 16'h0000, 8'h06, 2'd1, 4'hA, 2'd2, 1'b0, 2'd0, 16'h0, 16'h5A5A, 16'h0006});
    wb_en = 1'b1; wb_dest = 2'd2; wb_data = 16'h5A5A;
    step();
    wb_en = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("skid_drained", 16'(sbq.size()), 0);
    // Flush with both entries full and a pending input.
    out_ready = 1'b0;
    v  = '{2'd1, 2'd1, 16'h0C0C, 16'h0D0D, 8'h00, 2'd0, 4'h1, 2'd1, 1'b0, 2'd0, 16'h0, 16'h0C0C, 16'h0D0D};
    v2 = '{2'd1, 2'd1, 16'h0E0E, 16'h0F0F, 8'h00, 2'd0, 4'h2, 2'd2, 1'b0, 2'd0, 16'h0, 16'h0E0E, 16'h0F0F};
    drive(v); drive(v2);
    apply(v); in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_full_out_valid", out_valid, 0);
    check("flush_full_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("flush_full_dropped", out_valid, 0);
    step();
    // Flush while in_ready is high: the offered input is dropped too.
    out_ready = 1'b0;
    drive(v);
    apply(v2); in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush_one_out_valid", out_valid, 0);
    check("flush_one_in_ready", in_ready, 1);
    step();
    // Reset mid-stall.
    drive(v); drive(v2);
    reset_n = 1'b0;
    step();
    @(negedge clk);
    check("rst_stall_out_valid", out_valid, 0);
    check("rst_stall_in_ready", in_ready, 1);
    check("rst_stall_a", out_a, 0);
    check("rst_stall_b", out_b, 0);
    check("rst_stall_op", {12'h0, out_op}, 0);
    check("rst_stall_dest", {14'h0, out_dest}, 0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    step();
    @(negedge clk);
    check("rst_stall_no_xfer", out_valid, 0);
    step();
    check("final_sb_empty", 16'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
